// File: rtl/iir_seq_ctrl_if.sv
// Handshake, coefficient-port and shared-arithmetic bundle for iir_seq_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface iir_seq_ctrl_if #(
    parameter int W  = 32,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_float;
    logic [W-1:0]  y_float;
    logic          out_valid;
    logic          out_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;
    logic          cfg_err;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_p;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_s;

    modport master (
        output in_valid, x_float, out_ready, coef_we, coef_addr, coef_data, mul_p, add_s,
        input  in_ready, y_float, out_valid, cfg_err, mul_a, mul_b, add_a, add_b
    );

    modport slave (
        input  in_valid, x_float, out_ready, coef_we, coef_addr, coef_data, mul_p, add_s,
        output in_ready, y_float, out_valid, cfg_err, mul_a, mul_b, add_a, add_b
    );
endinterface

// File: rtl/iir_seq_ctrl.sv
// Serial IIR controller: one tap per cycle through an external float multiplier/adder.
// Optional IIR_NAN_GUARD_EN: zero Inf/NaN results, clear y history on them, sticky nan_flag.
module iir_seq_ctrl #(
    parameter int MAN = 23,
    parameter int EXP = 8,
    parameter int NB  = 8,
    parameter int NA  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    output logic busy,
`ifdef IIR_NAN_GUARD_EN
    output logic nan_flag,
`endif
    iir_seq_ctrl_if.slave bus
);
    localparam int W  = MAN + EXP + 1;
    localparam int NT = NB + NA;
    localparam int KW = $clog2(NT);
    localparam int XW = $clog2(NB);
    localparam int YW = $clog2(NA);
    localparam logic [W-1:0] SIGN_BIT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t         state_reg;
    logic [KW-1:0]  k_reg;
    logic [W-1:0]   acc_reg;
    logic [W-1:0]   y_reg;
    logic           in_ready_reg;
    logic           out_valid_reg;
    logic           busy_reg;
    logic           cfg_err_reg;
    logic [W-1:0]   coef_reg [NT];
    logic [W-1:0]   xh_reg   [NB];
    logic [W-1:0]   yh_reg   [NA];   // yh_reg[j] holds y[n-1-j]
`ifdef IIR_NAN_GUARD_EN
    logic           nan_reg;
    assign nan_flag = nan_reg;
`endif

    logic [XW-1:0]  x_idx;
    logic [YW-1:0]  y_idx;
    logic           last_tap;

    assign x_idx    = XW'(k_reg);
    assign y_idx    = YW'(k_reg - KW'(NB));
    assign last_tap = (k_reg == KW'(NT - 1));

    // Feedback taps use the negated coefficient so the adder always accumulates.
    always_comb begin
        bus.mul_a = '0;
        bus.mul_b = '0;
        bus.add_a = '0;
        bus.add_b = '0;
        if (state_reg == S_MAC) begin
            if (k_reg < KW'(NB)) begin
                bus.mul_a = coef_reg[k_reg];
                bus.mul_b = xh_reg[x_idx];
            end else begin
                bus.mul_a = coef_reg[k_reg] ^ SIGN_BIT;
                bus.mul_b = yh_reg[y_idx];
            end
            bus.add_a = acc_reg;
            bus.add_b = bus.mul_p;
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.y_float   = y_reg;
    assign bus.cfg_err   = cfg_err_reg;
    assign busy          = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            y_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
            for (int i = 0; i < NT; i++) coef_reg[i] <= '0;
            for (int i = 0; i < NB; i++) xh_reg[i] <= '0;
            for (int i = 0; i < NA; i++) yh_reg[i] <= '0;
`ifdef IIR_NAN_GUARD_EN
            nan_reg       <= 1'b0;
`endif
        end else begin
            cfg_err_reg <= 1'b0;
            if (bus.coef_we) begin
                if (state_reg == S_IDLE && int'(bus.coef_addr) < NT)
                    coef_reg[bus.coef_addr] <= bus.coef_data;
                else
                    cfg_err_reg <= 1'b1;
            end

            if (flush) begin
                state_reg     <= S_IDLE;
                k_reg         <= '0;
                acc_reg       <= '0;
                y_reg         <= '0;
                in_ready_reg  <= 1'b1;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
                for (int i = 0; i < NB; i++) xh_reg[i] <= '0;
                for (int i = 0; i < NA; i++) yh_reg[i] <= '0;
`ifdef IIR_NAN_GUARD_EN
                nan_reg       <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            for (int i = NB - 1; i > 0; i--) xh_reg[i] <= xh_reg[i-1];
                            xh_reg[0]    <= bus.x_float;
                            acc_reg      <= '0;
                            k_reg        <= '0;
                            state_reg    <= S_MAC;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                        end
                    end
                    S_MAC: begin
                        acc_reg <= bus.add_s;
                        if (last_tap) begin
                            state_reg     <= S_OUT;
                            out_valid_reg <= 1'b1;
`ifdef IIR_NAN_GUARD_EN
                            if (&bus.add_s[W-2:MAN]) begin
                                y_reg   <= '0;
                                nan_reg <= 1'b1;
                            end else begin
                                y_reg   <= bus.add_s;
                            end
`else
                            y_reg         <= bus.add_s;
`endif
                        end else begin
                            k_reg <= k_reg + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (bus.out_ready) begin
`ifdef IIR_NAN_GUARD_EN
                            if (&acc_reg[W-2:MAN]) begin
                                for (int i = 0; i < NA; i++) yh_reg[i] <= '0;
                            end else begin
                                for (int i = NA - 1; i > 0; i--) yh_reg[i] <= yh_reg[i-1];
                                yh_reg[0] <= acc_reg;
                            end
`else
                            for (int i = NA - 1; i > 0; i--) yh_reg[i] <= yh_reg[i-1];
                            yh_reg[0] <= acc_reg;
`endif
                            state_reg     <= S_IDLE;
                            out_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            y_reg         <= '0;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Bench for iir_seq_ctrl: real-valued float units on the operand ports, a difference-equation
// reference model feeding a scoreboard queue, and a monitor that checks every output handshake.
module tb_iir_seq_ctrl;
    localparam int MAN = 23;
    localparam int EXP = 8;
    localparam int NB  = 8;
    localparam int NA  = 8;
    localparam int W   = MAN + EXP + 1;
    localparam int NT  = NB + NA;
    localparam int AW  = $clog2(NT);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef IIR_NAN_GUARD_EN
    logic nan_flag;
`endif

    iir_seq_ctrl_if #(.W(W), .AW(AW)) bus ();

    iir_seq_ctrl #(.MAN(MAN), .EXP(EXP), .NB(NB), .NA(NA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .busy     (busy),
`ifdef IIR_NAN_GUARD_EN
        .nan_flag (nan_flag),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Decode/encode single precision; stimulus is dyadic so every value is exact.
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic s;
        real  m;
        int   e;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    always_comb bus.mul_p = r2f(f2r(bus.mul_a) * f2r(bus.mul_b));
    always_comb bus.add_s = r2f(f2r(bus.add_a) + f2r(bus.add_b));

    // Reference model: y[n] = sum b[i]*x[n-i] - sum a[j]*y[n-j]
    real mb [NB];
    real ma [NA+1];
    real mx [NB];
    real my [NA+1];
    logic [31:0] exp_q [$];

    logic [31:0] x_set [9] = '{32'h00000000, 32'h3F000000, 32'hBF000000, 32'h3F800000,
                               32'hBF800000, 32'h40000000, 32'hC0000000, 32'h40800000,
                               32'hC0800000};
    logic [31:0] b_set [8] = '{32'h00000000, 32'h3E800000, 32'hBE800000, 32'h3F000000,
                               32'hBF000000, 32'h3F800000, 32'hBF800000, 32'h40000000};
    logic [31:0] a_set [5] = '{32'h00000000, 32'h3E800000, 32'hBE800000, 32'h3F000000,
                               32'hBF000000};

    task automatic model_accept(input real x);
        real y;
        for (int i = NB - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
        y = 0.0;
        for (int i = 0; i < NB; i++) y = y + mb[i] * mx[i];
        for (int j = 1; j <= NA; j++) y = y - ma[j] * my[j];
        exp_q.push_back(r2f(y));
        for (int j = NA; j > 1; j--) my[j] = my[j-1];
        my[1] = y;
    endtask

    task automatic model_clear_state();
        for (int i = 0; i < NB; i++) mx[i] = 0.0;
        for (int j = 0; j <= NA; j++) my[j] = 0.0;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, req);
        end
    endtask

    // Scoreboard monitor: one line per output transaction.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_checks++;
            n_out++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", bus.y_float);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.y_float !== e) begin
                    n_fail++;
                    $display("FAIL y_float #%0d: got %h, expected %h", n_out, bus.y_float, e);
                end else begin
                    $display("out #%0d y_float=%h ok", n_out, bus.y_float);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [31:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = d;
        tick();
        bus.coef_we   = 1'b0;
        if (addr < NB) mb[addr] = f2r(d);
        else           ma[addr-NB+1] = f2r(d);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 200) begin tick(); n++; end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Presents one sample; returns in the first MAC cycle (k=0).
    task automatic send(input logic [31:0] x);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.x_float  = x;
        tick();
        bus.in_valid = 1'b0;
        model_accept(f2r(x));
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 60) begin tick(); n++; end
        if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear_state();
    endtask

    initial begin
        int lat;
        int seen;
        bus.in_valid  = 1'b0;
        bus.x_float   = '0;
        bus.out_ready = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        for (int i = 0; i < NB; i++) mb[i] = 0.0;
        for (int j = 0; j <= NA; j++) ma[j] = 0.0;
        model_clear_state();

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_y_float", bus.y_float, 32'h00000000);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cfg_err", 32'(bus.cfg_err), 32'd0);

        // Pure gain and latency
        write_coef(0, 32'h3F800000);
        send(32'h40000000);
        check("mac_busy", 32'(busy), 32'd1);
        check("mac_in_ready", 32'(bus.in_ready), 32'd0);
        check("mac_k0_mul_a", bus.mul_a, 32'h3F800000);
        check("mac_k0_mul_b", bus.mul_b, 32'h40000000);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin tick(); lat++; end
        check("latency", 32'(lat), 32'd17);
        wait_ready();
        check("idle_mul_a_zero", bus.mul_a, 32'h0);
        check("idle_add_a_zero", bus.add_a, 32'h0);

        // Feedback impulse
        do_flush();
        write_coef(NB, 32'hBF000000);
        send(32'h3F800000);
        send(32'h00000000);
        send(32'h00000000);
        wait_ready();

        // Backpressure: expected 0.125 continuing the impulse response
        bus.out_ready = 1'b0;
        send(32'h00000000);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.x_float  = x_set[$urandom_range(0, 8)];
            tick();
            check("bp_y_stable", bus.y_float, 32'h3E000000);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Config rejection in MAC, then accepted writes in IDLE
        send(32'h00000000);
        tick();
        tick();
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = 32'h40400000;
        tick();
        bus.coef_we   = 1'b0;
        check("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
        tick();
        check("cfg_err_clear", 32'(bus.cfg_err), 32'd0);
        wait_ready();
        write_coef(0, 32'h40400000);
        check("cfg_err_idle_write", 32'(bus.cfg_err), 32'd0);
        send(32'h3F800000);
        wait_ready();
        // Write and sample in the same cycle: new b0 must be used
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = 32'h3F800000;
        bus.in_valid  = 1'b1;
        bus.x_float   = 32'h3F800000;
        tick();
        bus.coef_we   = 1'b0;
        bus.in_valid  = 1'b0;
        mb[0] = 1.0;
        model_accept(1.0);
        check("cfg_err_same_cycle", 32'(bus.cfg_err), 32'd0);
        wait_ready();

        // Flush at k=5 discards the sample and the history
        send(32'h3F800000);
        repeat (5) tick();
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_float  = 32'h40000000;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        model_clear_state();
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("flush_no_output", 32'(seen), 32'd0);
        send(32'h3F800000);
        wait_ready();

        // Randomized batches against the reference model
        for (int bt = 0; bt < 5; bt++) begin
            do_flush();
            for (int a = 0; a < NT; a++) begin
                logic [31:0] c;
                c = 32'h0;
                if (a < NB)          c = b_set[$urandom_range(0, 7)];
                else if (a == NB)    c = a_set[$urandom_range(0, 4)];
                else if (a == NB+1)  c = a_set[$urandom_range(0, 2)];
                write_coef(a, c);
            end
            for (int s = 0; s < 6; s++) begin
                int r;
                r = $urandom_range(0, 3);
                bus.out_ready = (r == 0);
                send(x_set[$urandom_range(0, 8)]);
                wait_out();
                repeat (r) tick();
                bus.out_ready = 1'b1;
                wait_ready();
            end
        end

        // Asynchronous reset mid-operation clears coefficients too
        send(32'h40000000);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < NB; i++) mb[i] = 0.0;
        for (int j = 0; j <= NA; j++) ma[j] = 0.0;
        model_clear_state();
        tick();
        rst_n = 1'b1;
        tick();
        send(32'h40000000);
        wait_ready();
        write_coef(0, 32'h3F800000);
        send(32'h40800000);
        wait_ready();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
